// File: rtl/popcount_pipe.sv
// Pipelined, back-pressured ones-count of a DEPTH-bit beat built from a 3:2 carry-save tree,
// with an optional saturating running total across beats.
module popcount_pipe #(
   parameter int DEPTH = 4,
   parameter int LAT   = 2,
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DEPTH-1:0] in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             mode,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] count,
   output logic             sat
);

   localparam int CW = $clog2(DEPTH + 1);

   typedef logic [DEPTH-1:0][CW-1:0] ops_t;

   function automatic int count_levels(input int d);
      int n;
      int l;
      n = d;
      l = 0;
      while (n > 2) begin
         n = n - n / 3;
         l = l + 1;
      end
      return l;
   endfunction

   function automatic int live_at(input int d, input int lvl);
      int n;
      n = d;
      for (int i = 0; i < lvl; i++) n = n - n / 3;
      return n;
   endfunction

   // One carry-save row: every group of three operands becomes sum + shifted carry;
   // two consecutive rows act as a 4:2 compressor. Leftover operands pass through.
   function automatic ops_t csa_level(input ops_t x, input int n);
      ops_t y;
      int   ng;
      logic [CW-1:0] a, b, c;
      y  = '0;
      ng = n / 3;
      for (int g = 0; g < DEPTH / 3; g++) begin
         if (g < ng) begin
            a          = x[3*g];
            b          = x[3*g+1];
            c          = x[3*g+2];
            y[2*g]     = a ^ b ^ c;
            y[2*g+1]   = ((a & b) | (a & c) | (b & c)) << 1;
         end
      end
      for (int r = 0; r < 2; r++) begin
         if (r < n - 3 * ng) y[2*ng+r] = x[3*ng+r];
      end
      return y;
   endfunction

   localparam int NLVL = count_levels(DEPTH);
   localparam int LP_C = (NLVL + LAT - 1) / LAT;
   localparam int LP   = (LP_C < 1) ? 1 : LP_C;
   localparam int NLA  = (NLVL < 1) ? 1 : NLVL;
   localparam int LR   = (LAT > 1) ? LAT - 1 : 1;

   ops_t in_ops;
   ops_t lvl_out       [0:NLA-1];
   ops_t stage_in      [1:LAT];
   ops_t stage_out     [1:LAT];
   ops_t stage_ops_reg [1:LR];
   logic [LR:1] stage_vld_reg;
   logic [LR:1] stage_mode_reg;
   logic [LR:0] vld_chain;
   logic [LR:0] mode_chain;

   logic             advance;
   logic             fin_vld;
   logic             fin_mode;
   logic [CW-1:0]    popcnt;
   logic             out_valid_reg, out_valid_next;
   logic [ACC_W-1:0] count_reg, count_next;
   logic [ACC_W-1:0] acc_reg, acc_next;
   logic             sat_reg, sat_next;
   logic [ACC_W-1:0] acc_base;
   logic             sat_base;
   logic [ACC_W:0]   sum_wide;

   assign advance  = !out_valid_reg || out_ready;
   assign in_ready = advance;

   genvar gi;

   for (gi = 0; gi < DEPTH; gi++) begin : g_in
      assign in_ops[gi] = CW'(in[gi]);
   end

   // Levels are spread evenly over the stages; a level that opens a stage reads that stage's input.
   for (gi = 0; gi < NLVL; gi++) begin : g_lvl
      localparam int S = gi / LP + 1;
      localparam int N = live_at(DEPTH, gi);
      ops_t lvl_in;
      if (gi % LP == 0) begin : g_first
         assign lvl_in = stage_in[S];
      end else begin : g_chain
         assign lvl_in = lvl_out[gi-1];
      end
      assign lvl_out[gi] = csa_level(lvl_in, N);
   end

   for (gi = 1; gi <= LAT; gi++) begin : g_stage
      if (gi == 1) begin : g_head
         assign stage_in[gi] = in_ops;
      end else begin : g_body
         assign stage_in[gi] = stage_ops_reg[gi-1];
      end
      if ((gi - 1) * LP < NLVL) begin : g_work
         assign stage_out[gi] = lvl_out[((gi * LP < NLVL) ? gi * LP : NLVL) - 1];
      end else begin : g_pass
         assign stage_out[gi] = stage_in[gi];
      end
   end

   assign vld_chain  = {stage_vld_reg, in_valid};
   assign mode_chain = {stage_mode_reg, mode};
   assign fin_vld    = vld_chain[LAT-1];
   assign fin_mode   = mode_chain[LAT-1];
   assign popcnt     = stage_out[LAT][0] + stage_out[LAT][1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 1; s <= LR; s++) stage_ops_reg[s] <= '0;
         stage_vld_reg  <= '0;
         stage_mode_reg <= '0;
      end else if (advance) begin
         for (int s = 1; s < LAT; s++) begin
            stage_ops_reg[s]  <= stage_out[s];
            stage_vld_reg[s]  <= vld_chain[s-1];
            stage_mode_reg[s] <= mode_chain[s-1];
         end
      end
   end

   // clear takes effect before an accumulating beat landing on the same edge.
   always_comb begin
      acc_base       = clear ? '0 : acc_reg;
      sat_base       = clear ? 1'b0 : sat_reg;
      sum_wide       = {1'b0, acc_base} + (ACC_W + 1)'(popcnt);
      acc_next       = acc_base;
      sat_next       = sat_base;
      count_next     = count_reg;
      out_valid_next = out_valid_reg;
      if (advance) begin
         out_valid_next = fin_vld;
         if (fin_vld) begin
            if (fin_mode) begin
               if (sum_wide[ACC_W]) begin
                  acc_next = '1;
                  sat_next = 1'b1;
               end else begin
                  acc_next = sum_wide[ACC_W-1:0];
               end
               count_next = acc_next;
            end else begin
               count_next = ACC_W'(popcnt);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         count_reg     <= '0;
         acc_reg       <= '0;
         sat_reg       <= 1'b0;
      end else begin
         out_valid_reg <= out_valid_next;
         count_reg     <= count_next;
         acc_reg       <= acc_next;
         sat_reg       <= sat_next;
      end
   end

   assign out_valid = out_valid_reg;
   assign count     = count_reg;
   assign sat       = sat_reg;

endmodule
